ladybird_uart_bus_master: RTL and testbench
===========================================

Name: ladybird_uart_bus_master

Overview:
- Debug/loader initiator. Takes a byte stream from a UART receiver, decodes host commands, and issues single-word read/write transactions as a bus initiator.
- Returns acknowledgement or read data as a byte stream to a UART transmitter.
- Sits beside the core as an extra crossbar initiator, so the host can load instruction/data RAM and peek/poke GPIO without the core running.

Parameters:
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width; fixed 4 bytes per word
- TIMEOUT, 24'd1_000_000, idle cycles between command bytes before abort
- BUS_TIMEOUT, 16'd4096, cycles waiting for gnt/rvalid before abort

Ports:
- clk_i  in  1  clock
- anrst_i  in  1  asynchronous active-low reset
- rx_valid  in  1  received byte strobe, 1 cycle
- rx_data  in  8  received byte
- tx_valid  out  1  byte to transmit valid
- tx_data  out  8  byte to transmit
- tx_ready  in  1  transmitter accepts byte when tx_valid&tx_ready
- bus_req  out  1  transaction request
- bus_we  out  1  1=write
- bus_addr  out  ADDR_W  word address, bits[1:0] forced 0
- bus_wdata  out  DATA_W  write data
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  read data valid
- bus_rdata  in  DATA_W  read data
- busy  out  1  command in progress (state != IDLE)

Behaviour:
- Reset: clk_i, reset anrst_i asynchronous active-low. All outputs 0; state IDLE; counters 0.
- Command frame, all multi-byte fields little-endian:
  - 'W' (0x57): opcode, addr[4], data[4]
  - 'R' (0x52): opcode, addr[4]
  - 'P' (0x50): opcode only (ping)
- States: IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT, RESP.
- IDLE, on rx_valid:
  - 0x57 or 0x52: latch opcode, byte_cnt=0, go ADDR.
  - 0x50: resp=0x06, go RESP.
  - Any other byte: resp=0x15 (NAK), go RESP.
- ADDR: each rx_valid shifts a byte into addr[8*byte_cnt +: 8]. After the 4th byte go DATA for 'W', BUS_REQ for 'R'.
- DATA: 4 bytes into wdata the same way, then BUS_REQ.
- BUS_REQ:
  - bus_req=1, bus_we=(op=='W'); addr/wdata stable while req is high.
  - On bus_gnt: req drops the next cycle. Write: resp=0x06, go RESP. Read: go BUS_WAIT.
  - bus_rvalid in the same cycle as gnt is accepted.
- BUS_WAIT: on bus_rvalid latch rdata, go RESP with 4 bytes queued, LSB first.
- RESP:
  - tx_valid=1 with the current byte; advance on tx_valid&tx_ready.
  - tx_data must not change while tx_valid=1 and not ready.
  - Back to IDLE after the last byte.
  - rx_valid in RESP is discarded.
- Inter-byte timeout: in ADDR/DATA, a counter runs from the last accepted byte. Reaching TIMEOUT gives silent abort to IDLE with partial fields discarded.
- Bus timeout: in BUS_REQ/BUS_WAIT, BUS_TIMEOUT cycles without gnt/rvalid:
  - deassert bus_req, resp=0x15, go RESP.
  - Late rvalid afterwards is ignored.
- Address low bits: addr[1:0] are always driven 0; misalignment is not reported.
- Latency: last command byte to bus_req is 1 cycle. Write gnt to tx_valid is 1 cycle. Read rvalid to tx_valid is 1 cycle.

Decomposition:
- Shared package ladybird_config gains: opcode constants CMD_WRITE=8'h57, CMD_READ=8'h52, CMD_PING=8'h50, RSP_ACK=8'h06, RSP_NAK=8'h15; state enum uart_bm_state_t.
- One natural sub-module: ladybird_uart_tx_shifter (4-byte LSB-first output queue with valid/ready hold). The FSM stays in the top.

Test Plan:
- Write: rx 57 00 00 00 80 EF BE AD DE -> bus_req with we=1, addr=0x8000_0000, wdata=0xDEADBEEF; gnt after 3 cycles -> tx 0x06, busy returns 0.
- Read: rx 52 04 00 00 90, rdata=0x12345678 with rvalid 2 cycles after gnt -> tx 78 56 34 12; tx_ready held low 5 cycles mid-stream -> tx_data stable throughout.
- Errors: rx 0x41 -> tx 0x15. rx 50 -> tx 0x06. Read with gnt never asserted -> bus_req low after BUS_TIMEOUT, tx 0x15.
- Inter-byte timeout: rx 57 00 00 then silence TIMEOUT cycles -> IDLE with no bus_req and no tx. Next full read command executes normally.
- Reset mid-operation: anrst_i low during BUS_WAIT -> bus_req, tx_valid, busy all 0 immediately. After release, a ping returns 0x06.

Source files
------------

// File: rtl/ladybird_config_pkg.sv
// Shared configuration for the ladybird SoC: UART loader opcodes, response
// bytes and the bus-master state encoding.
package ladybird_config;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_PING  = 8'h50;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS_REQ,
        S_BUS_WAIT,
        S_RESP
    } uart_bm_state_t;

    // Opcodes that carry an address field and end in a bus transaction.
    function automatic logic is_bus_cmd(input logic [7:0] b);
        return (b == CMD_WRITE) || (b == CMD_READ);
    endfunction

endpackage

// File: rtl/ladybird_uart_tx_shifter.sv
// Up-to-4-byte response queue, LSB first. The head byte is held on tx_data
// until the transmitter takes it, so the output never changes mid-handshake.
module ladybird_uart_tx_shifter (
    input  logic        clk_i,
    input  logic        anrst_i,
    input  logic        load,
    input  logic [2:0]  load_cnt,
    input  logic [31:0] load_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        done
);

    logic [31:0] sh_q;
    logic [2:0]  cnt_q;

    assign tx_valid = (cnt_q != 3'd0);
    assign tx_data  = sh_q[7:0];
    assign done     = tx_valid && tx_ready && (cnt_q == 3'd1);

    // Load a fresh response, or pop the head byte on each accepted handshake.
    always_ff @(posedge clk_i or negedge anrst_i) begin
        if (!anrst_i) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            sh_q  <= load_data;
            cnt_q <= load_cnt;
        end else if (tx_valid && tx_ready) begin
            sh_q  <= {8'h00, sh_q[31:8]};
            cnt_q <= cnt_q - 3'd1;
        end
    end

endmodule

// File: rtl/ladybird_uart_bus_master.sv
// UART-driven debug/loader bus initiator: decodes W/R/P host commands from
// the receive byte stream, runs one bus word transaction, and answers with
// ACK/NAK or the read word over the transmit byte stream.
module ladybird_uart_bus_master
    import ladybird_config::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter logic [23:0] TIMEOUT     = 24'd1_000_000,
    parameter logic [15:0] BUS_TIMEOUT = 16'd4096
) (
    input  logic              clk_i,
    input  logic              anrst_i,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy
);

    uart_bm_state_t state_q, state_d;

    logic        op_wr_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [23:0] idle_cnt_q;
    logic [15:0] bus_cnt_q;

    logic        idle_to;
    logic        bus_to;
    logic        ld;
    logic [2:0]  ld_cnt;
    logic [31:0] ld_data;
    logic [7:0]  idle_rsp;
    logic        tx_done;

    // Timeouts fire on the cycle the counter would reach its limit.
    assign idle_to  = (idle_cnt_q == TIMEOUT - 24'd1) && !rx_valid;
    assign bus_to   = (bus_cnt_q == BUS_TIMEOUT - 16'd1);
    assign idle_rsp = (rx_data == CMD_PING) ? RSP_ACK : RSP_NAK;

    assign bus_req   = (state_q == S_BUS_REQ);
    assign bus_we    = (state_q == S_BUS_REQ) && op_wr_q;
    assign bus_addr  = addr_q[ADDR_W-1:0];
    assign bus_wdata = wdata_q[DATA_W-1:0];
    assign busy      = (state_q != S_IDLE);

    // State register.
    always_ff @(posedge clk_i or negedge anrst_i) begin
        if (!anrst_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state and response-queue load.
    always_comb begin
        state_d = state_q;
        ld      = 1'b0;
        ld_cnt  = 3'd0;
        ld_data = '0;
        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (is_bus_cmd(rx_data)) begin
                        state_d = S_ADDR;
                    end else begin
                        ld      = 1'b1;
                        ld_cnt  = 3'd1;
                        ld_data = {24'd0, idle_rsp};
                        state_d = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    if (byte_cnt_q == 2'd3) state_d = op_wr_q ? S_DATA : S_BUS_REQ;
                end else if (idle_to) begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    if (byte_cnt_q == 2'd3) state_d = S_BUS_REQ;
                end else if (idle_to) begin
                    state_d = S_IDLE;
                end
            end
            S_BUS_REQ: begin
                if (bus_gnt) begin
                    if (op_wr_q) begin
                        ld      = 1'b1;
                        ld_cnt  = 3'd1;
                        ld_data = {24'd0, RSP_ACK};
                        state_d = S_RESP;
                    end else if (bus_rvalid) begin
                        // Zero-wait-state slave: data arrives with the grant.
                        ld      = 1'b1;
                        ld_cnt  = 3'd4;
                        ld_data = bus_rdata;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_BUS_WAIT;
                    end
                end else if (bus_to) begin
                    ld      = 1'b1;
                    ld_cnt  = 3'd1;
                    ld_data = {24'd0, RSP_NAK};
                    state_d = S_RESP;
                end
            end
            S_BUS_WAIT: begin
                if (bus_rvalid) begin
                    ld      = 1'b1;
                    ld_cnt  = 3'd4;
                    ld_data = bus_rdata;
                    state_d = S_RESP;
                end else if (bus_to) begin
                    ld      = 1'b1;
                    ld_cnt  = 3'd1;
                    ld_data = {24'd0, RSP_NAK};
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (tx_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command field capture plus the inter-byte and bus wait counters.
    always_ff @(posedge clk_i or negedge anrst_i) begin
        if (!anrst_i) begin
            op_wr_q    <= 1'b0;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            idle_cnt_q <= '0;
            bus_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    bus_cnt_q <= '0;
                    if (rx_valid && is_bus_cmd(rx_data)) begin
                        op_wr_q    <= (rx_data == CMD_WRITE);
                        byte_cnt_q <= '0;
                        addr_q     <= '0;
                        wdata_q    <= '0;
                        idle_cnt_q <= '0;
                    end
                end
                S_ADDR, S_DATA: begin
                    if (rx_valid) begin
                        // Word addressing: the two low address bits never leave the block.
                        if (state_q == S_ADDR)
                            addr_q[{byte_cnt_q, 3'b000} +: 8] <=
                                rx_data & ((byte_cnt_q == 2'd0) ? 8'hFC : 8'hFF);
                        else
                            wdata_q[{byte_cnt_q, 3'b000} +: 8] <= rx_data;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        idle_cnt_q <= '0;
                    end else if (idle_to) begin
                        addr_q  <= '0;
                        wdata_q <= '0;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 24'd1;
                    end
                end
                S_BUS_REQ:  bus_cnt_q <= bus_gnt ? 16'd0 : bus_cnt_q + 16'd1;
                S_BUS_WAIT: bus_cnt_q <= bus_cnt_q + 16'd1;
                default:    bus_cnt_q <= '0;
            endcase
        end
    end

    ladybird_uart_tx_shifter u_tx (
        .clk_i     (clk_i),
        .anrst_i   (anrst_i),
        .load      (ld),
        .load_cnt  (ld_cnt),
        .load_data (ld_data),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .done      (tx_done)
    );

endmodule

// File: tb/tb_ladybird_uart_bus_master.sv
// Bench for ladybird_uart_bus_master: table vectors from the plan, random
// commands against a frame-level model, and hand sequences for timeouts and
// asynchronous reset.
module tb_ladybird_uart_bus_master;
    import ladybird_config::*;

    localparam logic [23:0] TMO  = 24'd60;
    localparam logic [15:0] BTMO = 16'd30;

    logic        clk_i = 1'b0;
    logic        anrst_i;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        busy;

    ladybird_uart_bus_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .BUS_TIMEOUT(BTMO)) dut (
        .clk_i(clk_i), .anrst_i(anrst_i), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .busy(busy)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr, data, rdata;
        int          gnt_dly;      // -1: never granted
        int          rv_dly;
        int          stall_after;  // tx byte index where ready is pulled low
        int          stall_len;
        int          exp_nreq;
        logic        exp_we;
        logic [31:0] exp_addr, exp_wdata;
        int          exp_ntx;
        logic [7:0]  exp_tx[4];
    } vec_t;

    typedef struct {
        int          n_req, req_total, first_req, gnt_cyc, rv_cyc, first_tx, ntx, end_cyc;
        logic        we;
        logic [31:0] addr, wdata;
        logic [7:0]  tx[8];
        bit          stable, done;
    } obs_t;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr, data, rdata,
                                input int gd, rd, sa, sl);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.rdata = rdata;
        v.gnt_dly = gd; v.rv_dly = rd; v.stall_after = sa; v.stall_len = sl;
        v.exp_nreq = 0; v.exp_we = 0; v.exp_addr = 0; v.exp_wdata = 0; v.exp_ntx = 0;
        v.exp_tx = '{default: 8'h00};
        return v;
    endfunction

    function automatic vec_t set_exp(input vec_t v, input int nreq, input logic we,
                                     input logic [31:0] a, wd, input int ntx,
                                     input logic [7:0] t0, t1, t2, t3);
        vec_t e = v;
        e.exp_nreq = nreq; e.exp_we = we; e.exp_addr = a; e.exp_wdata = wd;
        e.exp_ntx = ntx; e.exp_tx = '{t0, t1, t2, t3};
        return e;
    endfunction

    // Frame-level reference: what the host should see for one command.
    function automatic vec_t model(input vec_t v);
        vec_t e = v;
        e.exp_nreq = 0; e.exp_we = 0; e.exp_addr = 0; e.exp_wdata = 0; e.exp_ntx = 1;
        e.exp_tx = '{default: 8'h00};
        if (v.op == CMD_WRITE || v.op == CMD_READ) begin
            e.exp_nreq  = 1;
            e.exp_we    = (v.op == CMD_WRITE);
            e.exp_addr  = v.addr - (v.addr % 4);
            e.exp_wdata = v.data;
            if (v.gnt_dly < 0) e.exp_tx[0] = RSP_NAK;
            else if (v.op == CMD_WRITE) e.exp_tx[0] = RSP_ACK;
            else begin
                e.exp_ntx = 4;
                for (int i = 0; i < 4; i++) e.exp_tx[i] = 8'((v.rdata >> (8 * i)) % 256);
            end
        end else begin
            e.exp_tx[0] = (v.op == CMD_PING) ? RSP_ACK : RSP_NAK;
        end
        return e;
    endfunction

    function automatic void build(input vec_t v, output logic [7:0] b[9], output int n);
        b = '{default: 8'h00};
        b[0] = v.op; n = 1;
        if (v.op == CMD_WRITE || v.op == CMD_READ) begin
            for (int i = 0; i < 4; i++) b[1 + i] = v.addr[8 * i +: 8];
            n = 5;
        end
        if (v.op == CMD_WRITE) begin
            for (int i = 0; i < 4; i++) b[5 + i] = v.data[8 * i +: 8];
            n = 9;
        end
    endfunction

    // Called at a negedge; returns at the negedge after the last byte's posedge.
    task automatic send_bytes(input logic [7:0] b[9], input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1; rx_data = b[i];
            @(negedge clk_i);
        end
        rx_valid = 1'b0; rx_data = 8'h00;
    endtask

    // Plays bus slave and UART transmitter until busy drops (bounded).
    task automatic service(input vec_t v, output obs_t o);
        obs_t r;
        int req_cyc = 0, rv_cnt = -1, stall_cnt = 0;
        bit hold = 0;
        logic [7:0] last = 8'h00;
        r.n_req = 0; r.req_total = 0; r.first_req = -1; r.gnt_cyc = -1; r.rv_cyc = -1;
        r.first_tx = -1; r.ntx = 0; r.end_cyc = -1; r.we = 0; r.addr = 0; r.wdata = 0;
        r.tx = '{default: 8'h00}; r.stable = 1; r.done = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            bus_gnt = 0; bus_rvalid = 0; tx_ready = 1; rx_valid = 0;
            if (!busy) begin r.done = 1; r.end_cyc = cyc; break; end
            if (rv_cnt > 0) rv_cnt--;
            if (bus_req) begin
                if (req_cyc == 0) begin
                    r.n_req++; r.we = bus_we; r.addr = bus_addr; r.wdata = bus_wdata;
                    if (r.first_req < 0) r.first_req = cyc;
                end else if (bus_we !== r.we || bus_addr !== r.addr || bus_wdata !== r.wdata) begin
                    r.stable = 0;
                end
                r.req_total++;
                if (v.gnt_dly >= 0 && req_cyc == v.gnt_dly) begin
                    bus_gnt = 1; r.gnt_cyc = cyc;
                    if (!bus_we) rv_cnt = v.rv_dly;
                end
                req_cyc++;
            end else begin
                req_cyc = 0;
            end
            if (rv_cnt == 0) begin
                bus_rvalid = 1; bus_rdata = v.rdata; r.rv_cyc = cyc; rv_cnt = -1;
            end
            if (tx_valid) begin
                if (r.first_tx < 0) r.first_tx = cyc;
                if (hold && tx_data !== last) r.stable = 0;
                if (r.ntx == v.stall_after && stall_cnt < v.stall_len) begin
                    tx_ready = 0; stall_cnt++;
                    rx_valid = 1; rx_data = CMD_PING;  // must be ignored while answering
                end
                if (tx_ready) begin
                    if (r.ntx < 8) r.tx[r.ntx] = tx_data;
                    r.ntx++; hold = 0;
                end else begin
                    hold = 1; last = tx_data;
                end
            end
            @(negedge clk_i);
        end
        bus_gnt = 0; bus_rvalid = 0; tx_ready = 0; rx_valid = 0;
        o = r;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [7:0] b[9];
        int n;
        obs_t o;
        build(v, b, n);
        send_bytes(b, n);
        service(v, o);
        chk($sformatf("%s done", tag), 32'(o.done), 32'd1);
        chk($sformatf("%s nreq", tag), o.n_req, v.exp_nreq);
        chk($sformatf("%s stable", tag), 32'(o.stable), 32'd1);
        if (v.exp_nreq > 0) begin
            chk($sformatf("%s we", tag), 32'(o.we), 32'(v.exp_we));
            chk($sformatf("%s addr", tag), o.addr, v.exp_addr);
            if (v.exp_we) chk($sformatf("%s wdata", tag), o.wdata, v.exp_wdata);
            if (v.gnt_dly >= 0) begin
                chk($sformatf("%s req_lat", tag), o.first_req, 0);
                if (v.exp_we) chk($sformatf("%s gnt2tx", tag), o.first_tx - o.gnt_cyc, 1);
                else          chk($sformatf("%s rv2tx", tag), o.first_tx - o.rv_cyc, 1);
            end else begin
                chk($sformatf("%s req_cycles", tag), o.req_total, 32'(BTMO));
            end
        end
        chk($sformatf("%s ntx", tag), o.ntx, v.exp_ntx);
        for (int i = 0; i < v.exp_ntx && i < 4; i++)
            chk($sformatf("%s tx%0d", tag, i), o.tx[i], v.exp_tx[i]);
    endtask

    vec_t tab[7];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        vec_t v;
        obs_t o;
        logic [7:0] b[9];
        int k;

        tab[0] = set_exp(mk(CMD_WRITE, 32'h8000_0000, 32'hDEAD_BEEF, 0, 3, 0, -1, 0),
                         1, 1, 32'h8000_0000, 32'hDEAD_BEEF, 1, RSP_ACK, 0, 0, 0);
        tab[1] = set_exp(mk(CMD_READ, 32'h9000_0004, 0, 32'h1234_5678, 0, 2, 1, 5),
                         1, 0, 32'h9000_0004, 0, 4, 8'h78, 8'h56, 8'h34, 8'h12);
        tab[2] = set_exp(mk(8'h41, 0, 0, 0, 0, 0, -1, 0), 0, 0, 0, 0, 1, RSP_NAK, 0, 0, 0);
        tab[3] = set_exp(mk(CMD_PING, 0, 0, 0, 0, 0, -1, 0), 0, 0, 0, 0, 1, RSP_ACK, 0, 0, 0);
        tab[4] = set_exp(mk(CMD_READ, 32'h0000_0100, 0, 32'hFFFF_FFFF, -1, 0, -1, 0),
                         1, 0, 32'h0000_0100, 0, 1, RSP_NAK, 0, 0, 0);
        tab[5] = set_exp(mk(CMD_WRITE, 32'h0000_1003, 32'h0102_0304, 0, 0, 0, 0, 3),
                         1, 1, 32'h0000_1000, 32'h0102_0304, 1, RSP_ACK, 0, 0, 0);
        tab[6] = set_exp(mk(CMD_READ, 32'h0000_0042, 0, 32'hA5C3_0F81, 0, 0, -1, 0),
                         1, 0, 32'h0000_0040, 0, 4, 8'h81, 8'h0F, 8'hC3, 8'hA5);

        anrst_i = 0; rx_valid = 0; rx_data = 0; tx_ready = 0;
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
        repeat (3) @(negedge clk_i);
        chk("rst bus_req", 32'(bus_req), 0);
        chk("rst bus_we", 32'(bus_we), 0);
        chk("rst bus_addr", bus_addr, 0);
        chk("rst bus_wdata", bus_wdata, 0);
        chk("rst tx_valid", 32'(tx_valid), 0);
        chk("rst tx_data", 32'(tx_data), 0);
        chk("rst busy", 32'(busy), 0);
        anrst_i = 1;
        @(negedge clk_i);

        for (int i = 0; i < 7; i++) run_vec(tab[i], $sformatf("tab%0d", i));

        // A read reply arriving after the bus timeout must be dropped.
        run_vec(tab[4], "bto");
        bus_rvalid = 1; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk_i);
        bus_rvalid = 0;
        chk("late rvalid busy", 32'(busy), 0);
        chk("late rvalid tx_valid", 32'(tx_valid), 0);

        // Inter-byte timeout: partial write abandoned silently.
        b = '{default: 8'h00};
        b[0] = CMD_WRITE;
        send_bytes(b, 3);
        v = mk(8'h00, 0, 0, 0, 0, 0, -1, 0);
        service(v, o);
        chk("ibt done", 32'(o.done), 1);
        chk("ibt nreq", o.n_req, 0);
        chk("ibt ntx", o.ntx, 0);
        chk("ibt window", 32'(o.end_cyc >= int'(TMO) - 1 && o.end_cyc <= int'(TMO) + 1), 1);
        run_vec(tab[1], "after_ibt");

        // Asynchronous reset while waiting for read data.
        build(tab[1], b, k);
        send_bytes(b, k);
        for (k = 0; k < 20 && !bus_req; k++) @(negedge clk_i);
        chk("rst_mid req", 32'(bus_req), 1);
        bus_gnt = 1;
        @(negedge clk_i);
        bus_gnt = 0;
        chk("rst_mid wait busy", 32'(busy), 1);
        chk("rst_mid wait req", 32'(bus_req), 0);
        @(negedge clk_i);
        anrst_i = 0;
        #1;
        chk("rst_mid bus_req", 32'(bus_req), 0);
        chk("rst_mid tx_valid", 32'(tx_valid), 0);
        chk("rst_mid busy", 32'(busy), 0);
        @(negedge clk_i);
        anrst_i = 1;
        @(negedge clk_i);
        run_vec(tab[3], "post_rst_ping");

        // Random commands against the frame-level model.
        for (int i = 0; i < 30; i++) begin
            int unsigned sel;
            logic [7:0] op;
            int gd;
            sel = $urandom_range(0, 3);
            case (sel)
                0: op = CMD_WRITE;
                1: op = CMD_READ;
                2: op = CMD_PING;
                default: begin
                    op = 8'($urandom_range(0, 255));
                    while (op == CMD_WRITE || op == CMD_READ || op == CMD_PING)
                        op = 8'($urandom_range(0, 255));
                end
            endcase
            gd = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
            v = mk(op, $urandom, $urandom, $urandom, gd, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
            run_vec(model(v), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
